svm_pattern_decoder: RTL

// - Receive side of the symmetrical SVM vector stream: samples the 8-bit switching vector and the period sync (generator interrupt).
// - Recovers per-period dwell times d1..d4, zero time t0 and sector/set index; flags malformed or asymmetric patterns.
// - Sits beside the SVM generator as a closed-loop monitor and as a self-check for the modulator.

---
 rtl/svm_pattern_decoder_pkg.sv | 45 ++++
 rtl/svm_pattern_decoder_if.sv | 29 ++
 rtl/svm_set_lookup.sv | 24 ++
 rtl/svm_pattern_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/svm_pattern_decoder_pkg.sv
// rtl/svm_pattern_decoder_pkg.sv - shared SVM types, limits and the set vector ROM
package svm_pkg;

    localparam int N_SEG          = 13;
    localparam int N_SET          = 18;
    localparam int PERIOD_MAX_DEF = 1023;
    localparam int TOL_DEF        = 1;

    typedef logic [7:0] vec_t;
    typedef logic [9:0] len_t;
    typedef logic [3:0] idx_t;

    localparam idx_t SEG_LAST = idx_t'(N_SEG - 1);
    localparam idx_t SEG_FULL = idx_t'(N_SEG);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CLOSE,
        ST_CALC
    } state_t;

    // Row s-1 holds V1..V7 of set s; a window plays V1..V7 then V6..V1.
    localparam vec_t SET_ROM [N_SET][7] = '{
        '{8'h15, 8'h06, 8'h11, 8'h13, 8'h0e, 8'h01, 8'h14},
        '{8'h15, 8'h11, 8'h06, 8'h13, 8'h01, 8'h0e, 8'h14},
        '{8'h14, 8'h01, 8'h0e, 8'h13, 8'h06, 8'h11, 8'h15},
        '{8'h14, 8'h0e, 8'h01, 8'h13, 8'h11, 8'h06, 8'h15},
        '{8'h13, 8'h06, 8'h15, 8'h11, 8'h0e, 8'h14, 8'h01},
        '{8'h13, 8'h15, 8'h06, 8'h11, 8'h14, 8'h0e, 8'h01},
        '{8'h0e, 8'h01, 8'h14, 8'h13, 8'h06, 8'h15, 8'h11},
        '{8'h0e, 8'h14, 8'h01, 8'h13, 8'h15, 8'h06, 8'h11},
        '{8'h11, 8'h06, 8'h15, 8'h13, 8'h01, 8'h14, 8'h0e},
        '{8'h11, 8'h15, 8'h06, 8'h13, 8'h14, 8'h01, 8'h0e},
        '{8'h01, 8'h0e, 8'h14, 8'h06, 8'h11, 8'h15, 8'h13},
        '{8'h01, 8'h14, 8'h0e, 8'h06, 8'h15, 8'h11, 8'h13},
        '{8'h06, 8'h11, 8'h15, 8'h01, 8'h0e, 8'h14, 8'h13},
        '{8'h06, 8'h15, 8'h11, 8'h01, 8'h14, 8'h0e, 8'h13},
        '{8'h15, 8'h03, 8'h0a, 8'h14, 8'h07, 8'h02, 8'h13},
        '{8'h14, 8'h02, 8'h07, 8'h13, 8'h0a, 8'h03, 8'h15},
        '{8'h13, 8'h03, 8'h0a, 8'h15, 8'h07, 8'h02, 8'h14},
        '{8'h13, 8'h02, 8'h07, 8'h14, 8'h0a, 8'h03, 8'h15}
    };

endpackage

// File: rtl/svm_pattern_decoder_if.sv
// rtl/svm_pattern_decoder_if.sv - vector stream in / recovered pattern out bundle
interface svm_pattern_decoder_if;
    import svm_pkg::*;

    logic       ce;
    vec_t       v_in;
    logic       sync_in;
    len_t       d1;
    len_t       d2;
    len_t       d3;
    len_t       d4;
    len_t       t0;
    logic [7:0] set_out;
    logic       valid;
    logic       seg_err;
    logic       sym_err;
    logic       set_err;

    modport master (
        output ce, v_in, sync_in,
        input  d1, d2, d3, d4, t0, set_out, valid, seg_err, sym_err, set_err
    );

    modport slave (
        input  ce, v_in, sync_in,
        output d1, d2, d3, d4, t0, set_out, valid, seg_err, sym_err, set_err
    );

endinterface

// File: rtl/svm_set_lookup.sv
// rtl/svm_set_lookup.sv - maps the first three vectors after V1 to a set index
module svm_set_lookup
    import svm_pkg::*;
(
    input  vec_t       vec1,
    input  vec_t       vec2,
    input  vec_t       vec3,
    output logic [7:0] set_idx,
    output logic       match
);

    // Scanning downward lets the lowest matching index win.
    always_comb begin
        set_idx = 8'h00;
        match   = 1'b0;
        for (int s = N_SET - 1; s >= 0; s--) begin
            if (SET_ROM[s][1] == vec1 && SET_ROM[s][2] == vec2 && SET_ROM[s][3] == vec3) begin
                set_idx = 8'(s + 1);
                match   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/svm_pattern_decoder.sv
// rtl/svm_pattern_decoder.sv - run-length capture of the SVM vector stream and per-period pattern recovery
module svm_pattern_decoder
    import svm_pkg::*;
#(
    parameter int PERIOD_MAX = PERIOD_MAX_DEF,
    parameter int TOL        = TOL_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    svm_pattern_decoder_if.slave bus
);

    localparam len_t LEN_MAX = len_t'(PERIOD_MAX);
    localparam len_t LEN_TOL = len_t'(TOL);

    state_t     state, state_nxt;
    logic       sync_q, rise;
    idx_t       seg_idx;
    len_t       run_len;
    vec_t       run_vec;
    logic       seg_ovf;
    vec_t       slot_vec [N_SEG];
    len_t       slot_len [N_SEG];
    vec_t       snap_vec [N_SEG];
    len_t       snap_len [N_SEG];
    logic       snap_seg_err;

    logic [12:0] sum_d1, sum_d2, sum_d3, sum_d4, sum_t0;
    logic        sym_now;
    len_t        diff;
    logic [7:0]  lk_set;
    logic        lk_match;

    len_t       c_d1, c_d2, c_d3, c_d4, c_t0;
    logic [7:0] c_set;
    logic       c_match, c_sym, c_seg;

    len_t       d1_r, d2_r, d3_r, d4_r, t0_r;
    logic [7:0] set_r;
    logic       valid_r, seg_err_r, sym_err_r, set_err_r;

    assign rise = bus.sync_in & ~sync_q;

    function automatic len_t sat10(input logic [12:0] s);
        return (s > 13'(LEN_MAX)) ? LEN_MAX : s[9:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (bus.ce) begin
            state <= state_nxt;
        end
    end

    // Capture runs in every non-idle state, so CLOSE/CALC only pace the result pipeline.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (rise) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (rise) state_nxt = ST_CLOSE;
            ST_CLOSE:   state_nxt = rise ? ST_CLOSE : ST_CALC;
            ST_CALC:    state_nxt = rise ? ST_CLOSE : ST_CAPTURE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 1'b0;
            seg_idx      <= '0;
            run_len      <= '0;
            run_vec      <= '0;
            seg_ovf      <= 1'b0;
            snap_seg_err <= 1'b0;
            for (int i = 0; i < N_SEG; i++) begin
                slot_vec[i] <= '0;
                slot_len[i] <= '0;
                snap_vec[i] <= '0;
                snap_len[i] <= '0;
            end
        end else if (bus.ce) begin
            sync_q <= bus.sync_in;
            if (state == ST_IDLE) begin
                if (rise) begin
                    seg_idx <= '0;
                    run_len <= 10'd1;
                    run_vec <= bus.v_in;
                    seg_ovf <= 1'b0;
                end
            end else if (rise) begin
                // The still-open run goes straight into the snapshot; the rise sample starts the next window.
                for (int i = 0; i < N_SEG; i++) begin
                    snap_vec[i] <= (idx_t'(i) == seg_idx) ? run_vec : slot_vec[i];
                    snap_len[i] <= (idx_t'(i) == seg_idx) ? run_len : slot_len[i];
                end
                snap_seg_err <= seg_ovf | (seg_idx != SEG_LAST);
                seg_idx      <= '0;
                run_len      <= 10'd1;
                run_vec      <= bus.v_in;
                seg_ovf      <= 1'b0;
            end else if (bus.v_in != run_vec) begin
                if (seg_idx < SEG_FULL) begin
                    slot_vec[seg_idx] <= run_vec;
                    slot_len[seg_idx] <= run_len;
                    seg_idx           <= seg_idx + 4'd1;
                end else begin
                    seg_ovf <= 1'b1;
                end
                run_len <= 10'd1;
                run_vec <= bus.v_in;
            end else if (run_len != LEN_MAX) begin
                run_len <= run_len + 10'd1;
            end
        end
    end

    always_comb begin
        sum_d1  = 13'(snap_len[1]) + 13'(snap_len[11]);
        sum_d2  = 13'(snap_len[2]) + 13'(snap_len[10]);
        sum_d3  = 13'(snap_len[4]) + 13'(snap_len[8]);
        sum_d4  = 13'(snap_len[5]) + 13'(snap_len[7]);
        sum_t0  = 13'(snap_len[0]) + 13'(snap_len[3]) + 13'(snap_len[6])
                + 13'(snap_len[9]) + 13'(snap_len[12]);
        sym_now = (snap_vec[0] != snap_vec[12]);
        diff    = '0;
        for (int k = 1; k <= 5; k++) begin
            diff = (snap_len[k] > snap_len[12-k]) ? (snap_len[k] - snap_len[12-k])
                                                  : (snap_len[12-k] - snap_len[k]);
            if (snap_vec[k] != snap_vec[12-k] || diff > LEN_TOL) begin
                sym_now = 1'b1;
            end
        end
    end

    svm_set_lookup u_lookup (
        .vec1    (snap_vec[1]),
        .vec2    (snap_vec[2]),
        .vec3    (snap_vec[3]),
        .set_idx (lk_set),
        .match   (lk_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_d1      <= '0;
            c_d2      <= '0;
            c_d3      <= '0;
            c_d4      <= '0;
            c_t0      <= '0;
            c_set     <= '0;
            c_match   <= 1'b0;
            c_sym     <= 1'b0;
            c_seg     <= 1'b0;
            d1_r      <= '0;
            d2_r      <= '0;
            d3_r      <= '0;
            d4_r      <= '0;
            t0_r      <= '0;
            set_r     <= '0;
            valid_r   <= 1'b0;
            seg_err_r <= 1'b0;
            sym_err_r <= 1'b0;
            set_err_r <= 1'b0;
        end else if (bus.ce) begin
            if (state == ST_CLOSE) begin
                c_d1    <= sat10(sum_d1);
                c_d2    <= sat10(sum_d2);
                c_d3    <= sat10(sum_d3);
                c_d4    <= sat10(sum_d4);
                c_t0    <= sat10(sum_t0);
                c_set   <= lk_set;
                c_match <= lk_match;
                c_sym   <= sym_now;
                c_seg   <= snap_seg_err;
            end
            valid_r <= (state == ST_CALC);
            if (state == ST_CALC) begin
                // A miscounted window carries no trustworthy slot mapping, so nothing else is reported.
                seg_err_r <= c_seg;
                d1_r      <= c_seg ? '0 : c_d1;
                d2_r      <= c_seg ? '0 : c_d2;
                d3_r      <= c_seg ? '0 : c_d3;
                d4_r      <= c_seg ? '0 : c_d4;
                t0_r      <= c_seg ? '0 : c_t0;
                set_r     <= c_seg ? '0 : c_set;
                sym_err_r <= ~c_seg & c_sym;
                set_err_r <= ~c_seg & ~c_match;
            end
        end
    end

    assign bus.d1      = d1_r;
    assign bus.d2      = d2_r;
    assign bus.d3      = d3_r;
    assign bus.d4      = d4_r;
    assign bus.t0      = t0_r;
    assign bus.set_out = set_r;
    assign bus.valid   = valid_r;
    assign bus.seg_err = seg_err_r;
    assign bus.sym_err = sym_err_r;
    assign bus.set_err = set_err_r;

endmodule
